gray_port_arbiter: RTL and testbench

//  Shares the single gray-image memory read port (gray_req/gray_ready/gray_addr/gray_data) among
//  N_REQ LBP window-fetch engines, e.g. two engines splitting the 128x128 image into halves.

---
 rtl/gray_port_arbiter_if.sv | 29 ++
 rtl/gray_port_arbiter.sv | 131 +++++++++++++
 tb/tb_gray_port_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/gray_port_arbiter_if.sv
// Engine-side and memory-side signals of the shared gray-image read port.
interface gray_port_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int AW    = 14,
  parameter int DW    = 8
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ-1:0]    ack;
  logic [DW-1:0]       rdata;
  logic [GW-1:0]       grant_id;
  logic                busy;
  logic                gray_req;
  logic [AW-1:0]       gray_addr;
  logic                gray_ready;
  logic [DW-1:0]       gray_data;

  modport master (
    output req, req_addr, gray_ready, gray_data,
    input  ack, rdata, grant_id, busy, gray_req, gray_addr
  );

  modport slave (
    input  req, req_addr, gray_ready, gray_data,
    output ack, rdata, grant_id, busy, gray_req, gray_addr
  );
endinterface

// File: rtl/gray_port_arbiter.sv
// Round-robin, burst-limited arbiter sharing the gray-image memory read port
// among N_REQ window-fetch engines; one read in flight at a time.
module gray_port_arbiter #(
  parameter int N_REQ     = 2,
  parameter int AW        = 14,
  parameter int DW        = 8,
  parameter int MEM_LAT   = 1,
  parameter int BURST_MAX = 9
) (
  input  logic               clk,
  input  logic               reset,
  gray_port_arbiter_if.slave bus
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DATA, ACK} state_t;

  state_t           state_q, state_n;
  logic             gray_req_q, gray_req_n;
  logic [AW-1:0]    gray_addr_q, gray_addr_n;
  logic [N_REQ-1:0] ack_q, ack_n;
  logic [DW-1:0]    rdata_q, rdata_n;
  logic [GW-1:0]    grant_q, grant_n;
  logic [GW-1:0]    ptr_q, ptr_n;
  logic [BW-1:0]    burst_q, burst_n;
  logic [LW-1:0]    lat_q, lat_n;
  logic             done_q, done_n;
  logic [GW-1:0]    rr_win, win_inc;

  // First requester at or after ptr, wrapping; descending scan lets the
  // closest one overwrite the rest.
  always_comb begin
    logic [GW-1:0] idx;
    idx    = '0;
    rr_win = ptr_q;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = GW'((int'(ptr_q) + k) % N_REQ);
      if (bus.req[idx]) rr_win = idx;
    end
  end

  assign win_inc = (rr_win == GW'(N_REQ - 1)) ? '0 : rr_win + 1'b1;

  always_comb begin
    state_n     = state_q;
    gray_req_n  = gray_req_q;
    gray_addr_n = gray_addr_q;
    ack_n       = ack_q;
    rdata_n     = rdata_q;
    grant_n     = grant_q;
    ptr_n       = ptr_q;
    burst_n     = burst_q;
    lat_n       = lat_q;
    done_n      = done_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          // done_q keeps the very first grant after reset out of burst continuation
          if (done_q && bus.req[grant_q] && int'(burst_q) < BURST_MAX - 1) begin
            burst_n = burst_q + 1'b1;
          end else begin
            grant_n = rr_win;
            burst_n = '0;
            ptr_n   = win_inc;
          end
          gray_addr_n = bus.req_addr[grant_n*AW +: AW];
          gray_req_n  = 1'b1;
          state_n     = REQ;
        end
      end
      REQ: begin
        if (bus.gray_ready) begin
          gray_req_n = 1'b0;
          lat_n      = LW'(MEM_LAT - 1);
          state_n    = DATA;
        end
      end
      DATA: begin
        if (lat_q == '0) begin
          rdata_n         = bus.gray_data;
          ack_n           = '0;
          ack_n[grant_q]  = 1'b1;
          state_n         = ACK;
        end else begin
          lat_n = lat_q - 1'b1;
        end
      end
      ACK: begin
        ack_n   = '0;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      grant_q     <= '0;
      ptr_q       <= '0;
      burst_q     <= '0;
      lat_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      gray_req_q  <= gray_req_n;
      gray_addr_q <= gray_addr_n;
      ack_q       <= ack_n;
      rdata_q     <= rdata_n;
      grant_q     <= grant_n;
      ptr_q       <= ptr_n;
      burst_q     <= burst_n;
      lat_q       <= lat_n;
      done_q      <= done_n;
    end
  end

  assign bus.gray_req  = gray_req_q;
  assign bus.gray_addr = gray_addr_q;
  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_gray_port_arbiter.sv
// Random engines and memory around gray_port_arbiter; a transaction-level
// arbitration model feeds a queue that a negedge monitor checks cycle by cycle.
module tb_gray_port_arbiter;
  localparam int N  = 3;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int ML = 2;
  localparam int BM = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  gray_port_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

  gray_port_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .MEM_LAT(ML), .BURST_MAX(BM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            arb;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  bit            acc_valid = 1'b0;
  int            acc_cycle = 0;
  logic [AW-1:0] acc_addr = '0;

  // arbitration model: run = grants in a row to 'last'
  bit has_prev = 1'b0;
  bit free = 1'b1;
  int last = 0;
  int run = 0;
  int ptr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // monitor
  int            mon_gid = 0;
  logic [DW-1:0] mon_rdata = '0;
  logic [N-1:0]  m_ack;
  bit            m_greq;
  bit            m_txn;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("rst_ack", 32'(bus.ack), 0);
      chk("rst_rdata", 32'(bus.rdata), 0);
      chk("rst_grant_id", 32'(bus.grant_id), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_gray_req", 32'(bus.gray_req), 0);
      chk("rst_gray_addr", 32'(bus.gray_addr), 0);
      mon_gid   = 0;
      mon_rdata = '0;
    end else begin
      m_txn  = (q.size() > 0) && (cyc > q[0].arb);
      m_ack  = '0;
      m_greq = 1'b0;
      if (m_txn) begin
        mon_gid = q[0].id;
        m_greq  = !acc_valid || (acc_cycle == cyc);
        if (acc_valid && cyc == acc_cycle + ML + 1) begin
          m_ack     = N'(1) << q[0].id;
          mon_rdata = q[0].data;
        end
      end
      chk("busy", 32'(bus.busy), 32'(m_txn));
      chk("gray_req", 32'(bus.gray_req), 32'(m_greq));
      if (m_greq) chk("gray_addr", 32'(bus.gray_addr), 32'(q[0].addr));
      chk("ack", 32'(bus.ack), 32'(m_ack));
      chk("grant_id", 32'(bus.grant_id), 32'(mon_gid));
      chk("rdata", 32'(bus.rdata), 32'(mon_rdata));
      if (m_ack != '0) void'(q.pop_front());
    end
  end

  // engines, memory and reference model
  initial begin
    bit            rel;
    bit            drain;
    bit            ack_now;
    int            ack_id;
    int            stall;
    int            nrst;
    int            w;
    logic [AW-1:0] a;
    logic [N-1:0]  rv;
    rel = 1'b0; drain = 1'b0; stall = 0; nrst = 0;
    bus.req = '0;
    bus.req_addr = '0;
    bus.gray_ready = 1'b0;
    bus.gray_data = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    rel = 1'b1;
    for (int step = 0; step < 3060; step++) begin
      @(posedge clk);
      #2;
      cyc++;
      drain = (step >= 3000);
      if (rel) begin
        reset = 1'b0;
        rel   = 1'b0;
      end
      ack_now = acc_valid && (q.size() > 0) && (cyc == acc_cycle + ML + 1);
      ack_id  = ack_now ? q[0].id : -1;

      // only offset ML carries the real word; any other sampling sees garbage
      if (acc_valid && cyc - acc_cycle == ML) bus.gray_data = mem[acc_addr];
      else bus.gray_data = mem[acc_addr] ^ DW'($urandom_range(1, 255));

      if (nrst < 4 && acc_valid && cyc > acc_cycle && cyc <= acc_cycle + ML &&
          $urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        rel   = 1'b1;
        nrst++;
        q.delete();
        free = 1'b1; has_prev = 1'b0; last = 0; run = 0; ptr = 0; acc_valid = 1'b0;
        continue;
      end

      for (int i = 0; i < N; i++) begin
        if (i == ack_id) begin
          bus.req[i] = !drain && ($urandom_range(0, 99) < 80);
          bus.req_addr[i*AW +: AW] = AW'($urandom);
        end else if (!bus.req[i]) begin
          if (!drain && $urandom_range(0, 99) < 25) begin
            bus.req[i] = 1'b1;
            bus.req_addr[i*AW +: AW] = AW'($urandom);
          end
        end else if ($urandom_range(0, 99) < 3) begin
          bus.req[i] = 1'b0;
        end else if ($urandom_range(0, 99) < 10) begin
          bus.req_addr[i*AW +: AW] = AW'($urandom);
        end
      end

      if (drain) bus.gray_ready = 1'b1;
      else if (stall > 0) begin
        bus.gray_ready = 1'b0;
        stall--;
      end else if ($urandom_range(0, 99) < 4) begin
        bus.gray_ready = 1'b0;
        stall = 4;
      end else bus.gray_ready = ($urandom_range(0, 99) < 75);
      if (q.size() > 0 && cyc > q[0].arb && !acc_valid && bus.gray_ready) begin
        acc_valid = 1'b1;
        acc_cycle = cyc;
        acc_addr  = bus.gray_addr;
      end

      rv = bus.req;
      if (free && rv != '0) begin
        if (has_prev && rv[last] && run < BM) begin
          w = last;
          run++;
        end else begin
          w = -1;
          for (int k = 0; k < N; k++)
            if (w < 0 && rv[(ptr + k) % N]) w = (ptr + k) % N;
          run  = 1;
          ptr  = (w + 1) % N;
          last = w;
        end
        a = bus.req_addr[w*AW +: AW];
        q.push_back('{id: w, addr: a, data: mem[a], arb: cyc});
        free      = 1'b0;
        acc_valid = 1'b0;
      end
      if (ack_now) begin
        free     = 1'b1;
        has_prev = 1'b1;
      end
    end
    @(negedge clk);
    chk("drain_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
